rect_draw_engine: RTL

Parametrised rectangle rasteriser that replaces the fixed-pattern drawing logic feeding the VGA framebuffer. On a start strobe it latches two corner coordinates, a mode and a colour, then walks the rectangle in raster order and emits one framebuffer write per pixel slot. Modes cover filled rectangles, outline-only rectangles and full-screen clears. Pixel pacing is a clock-enable period instead of a divided clock, so the block runs entirely on the 50 MHz system clock alongside `VGA_framebuffer`.

---
 rtl/rect_draw_engine.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: walks a clamped rectangle in raster order and
// emits one framebuffer write per pixel slot, paced by a clock enable.
module rect_draw_engine #(
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int PIX_PERIOD = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic [1:0]     mode,
  input  logic           color,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           pixel_color,
  output logic           pixel_write
);

  localparam int PW = (PIX_PERIOD > 1) ? $clog2(PIX_PERIOD) : 1;
  localparam logic [X_W-1:0] XMAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] YMAX = Y_W'(SCREEN_H - 1);
  localparam logic [PW-1:0] PACE_LAST = PW'(PIX_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t         r_state, w_state;
  logic [X_W-1:0] r_lo_x, w_lo_x;
  logic [X_W-1:0] r_hi_x, w_hi_x;
  logic [Y_W-1:0] r_lo_y, w_lo_y;
  logic [Y_W-1:0] r_hi_y, w_hi_y;
  logic [X_W-1:0] r_x, w_x;
  logic [Y_W-1:0] r_y, w_y;
  logic           r_color, w_color;
  logic           r_outline, w_outline;
  logic [PW-1:0]  r_pace, w_pace;
  logic           r_busy, w_busy;
  logic           r_done, w_done;
  logic           r_write, w_write;

  logic [X_W-1:0] w_xmin, w_xmax, w_sx_lo, w_sx_hi;
  logic [Y_W-1:0] w_ymin, w_ymax, w_sy_lo, w_sy_hi;
  logic [X_W-1:0] w_nx;
  logic [Y_W-1:0] w_ny;
  logic           w_last;
  logic           w_interior;

  // Sorted, clamped corners; clamping commutes with min/max.
  always_comb begin
    w_xmin  = (x0 < x1) ? x0 : x1;
    w_xmax  = (x0 < x1) ? x1 : x0;
    w_ymin  = (y0 < y1) ? y0 : y1;
    w_ymax  = (y0 < y1) ? y1 : y0;
    w_sx_lo = (w_xmin > XMAX) ? XMAX : w_xmin;
    w_sx_hi = (w_xmax > XMAX) ? XMAX : w_xmax;
    w_sy_lo = (w_ymin > YMAX) ? YMAX : w_ymin;
    w_sy_hi = (w_ymax > YMAX) ? YMAX : w_ymax;
    if (mode == 2'b10) begin
      w_sx_lo = '0;
      w_sx_hi = XMAX;
      w_sy_lo = '0;
      w_sy_hi = YMAX;
    end
  end

  always_comb begin
    w_last     = (r_x == r_hi_x) && (r_y == r_hi_y);
    w_interior = r_outline && (r_y != r_lo_y) && (r_y != r_hi_y);
    w_nx       = r_x + 1'b1;
    w_ny       = r_y;
    if (r_x == r_hi_x) begin
      w_nx = r_lo_x;
      w_ny = r_y + 1'b1;
    end else if (w_interior && (r_x == r_lo_x)) begin
      w_nx = r_hi_x;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_lo_x    = r_lo_x;
    w_hi_x    = r_hi_x;
    w_lo_y    = r_lo_y;
    w_hi_y    = r_hi_y;
    w_x       = r_x;
    w_y       = r_y;
    w_color   = r_color;
    w_outline = r_outline;
    w_pace    = r_pace;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_write   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_state = IDLE;
        if (start) begin
          w_state   = SCAN;
          w_lo_x    = w_sx_lo;
          w_hi_x    = w_sx_hi;
          w_lo_y    = w_sy_lo;
          w_hi_y    = w_sy_hi;
          w_x       = w_sx_lo;
          w_y       = w_sy_lo;
          w_color   = color;
          w_outline = (mode == 2'b01);
          w_pace    = '0;
          w_busy    = 1'b1;
          w_write   = 1'b1;
        end
      end
      SCAN: begin
        if (abort) begin
          w_state = IDLE;
        end else if (w_last) begin
          w_state = DONE;
          w_done  = 1'b1;
        end else if (r_pace == PACE_LAST) begin
          w_x     = w_nx;
          w_y     = w_ny;
          w_pace  = '0;
          w_busy  = 1'b1;
          w_write = 1'b1;
        end else begin
          w_pace = r_pace + 1'b1;
          w_busy = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_lo_x    <= '0;
      r_hi_x    <= '0;
      r_lo_y    <= '0;
      r_hi_y    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_color   <= 1'b0;
      r_outline <= 1'b0;
      r_pace    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_write   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_lo_x    <= w_lo_x;
      r_hi_x    <= w_hi_x;
      r_lo_y    <= w_lo_y;
      r_hi_y    <= w_hi_y;
      r_x       <= w_x;
      r_y       <= w_y;
      r_color   <= w_color;
      r_outline <= w_outline;
      r_pace    <= w_pace;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_write   <= w_write;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign x           = r_x;
  assign y           = r_y;
  assign pixel_color = r_color;
  assign pixel_write = r_write;

endmodule
